ahb_lite_sp_sram_byte_ctrl: RTL and testbench

AHB-Lite slave that acts as the initiator for the 2048x8 single-port SRAM wrapper. It serialises byte, halfword and word AHB transfers into consecutive single-byte SRAM accesses, inserting wait states, and assembles read bytes into the 32-bit HRDATA. It sits between one AHB matrix slave port and one 8-bit SRAM wrapper instance in the MCU memory subsystem.

---
 rtl/ahb_lite_sp_sram_byte_ctrl_pkg.sv | 45 ++++
 rtl/ahb_lite_sp_sram_byte_ctrl_if.sv | 29 ++
 rtl/ahb_lite_sp_sram_byte_ctrl.sv | 157 +++++++++++++++
 tb/tb_ahb_lite_sp_sram_byte_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_sp_sram_byte_ctrl_pkg.sv
// Shared AHB-Lite encodings and controller state definitions.
// Imported by the byte-serialising SRAM controller.
package ahb_lite_sp_sram_byte_ctrl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_RDLAST = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    // Oversized or misaligned transfers are rejected with a two-cycle ERROR.
    function automatic logic xfer_illegal(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: xfer_illegal = 1'b0;
            HSIZE_HALF: xfer_illegal = addr_lo[0];
            HSIZE_WORD: xfer_illegal = (addr_lo != 2'b00);
            default:    xfer_illegal = 1'b1;
        endcase
    endfunction

    // Index of the final byte in a transfer (N-1).
    function automatic logic [1:0] size_last_k(input logic [2:0] size);
        case (size)
            HSIZE_BYTE: size_last_k = 2'd0;
            HSIZE_HALF: size_last_k = 2'd1;
            default:    size_last_k = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_sp_sram_byte_ctrl_if.sv
// AHB-Lite slave port plus 8-bit SRAM initiator port of the byte controller.
// slave = controller side, master = bus/SRAM environment side.
interface ahb_lite_sp_sram_byte_ctrl_if #(parameter int ADDR_WIDTH = 11);
    logic                  hsel;
    logic [31:0]           haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [31:0]           hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic                  hresp;
    logic [31:0]           hrdata;
    logic                  sram_cs;
    logic                  sram_wen;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [7:0]            sram_data;
    logic [7:0]            sram_q;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready, sram_q,
        output hreadyout, hresp, hrdata, sram_cs, sram_wen, sram_addr, sram_data
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready, sram_q,
        input  hreadyout, hresp, hrdata, sram_cs, sram_wen, sram_addr, sram_data
    );
endinterface

// File: rtl/ahb_lite_sp_sram_byte_ctrl.sv
// AHB-Lite slave serialising byte/half/word transfers into single-byte SRAM strobes.
// Data phase N cycles (write) or N+1 (read); hreadyout stalls the bus until the last byte.
module ahb_lite_sp_sram_byte_ctrl
    import ahb_lite_sp_sram_byte_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                                   clk,
    input  logic                                   rst,
    ahb_lite_sp_sram_byte_ctrl_if.slave            bus
);

    state_t                state, state_nxt;
    logic [1:0]            k, k_nxt;
    logic [1:0]            lane, lane_nxt;
    logic [1:0]            last_k, last_k_nxt;
    logic [ADDR_WIDTH-1:0] base, base_nxt;
    logic                  rd_pend, rd_pend_nxt;
    logic [1:0]            rd_lane, rd_lane_nxt;
    logic [31:0]           hrdata_q, hrdata_nxt, rdata_merged;

    logic                  accept;
    logic                  illegal;
    logic                  take_addr;
    logic                  start_read;
    logic [1:0]            byte_lane;

    logic                  hreadyout;
    logic                  hresp;
    logic                  sram_cs;
    logic                  sram_wen;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [7:0]            sram_data;

    logic                  unused_haddr_hi;
    assign unused_haddr_hi = ^bus.haddr[31:ADDR_WIDTH];

    assign accept  = bus.hsel & bus.hready &
                     (bus.htrans != HTRANS_IDLE) & (bus.htrans != HTRANS_BUSY);
    assign illegal   = xfer_illegal(bus.hsize, bus.haddr[1:0]);
    assign byte_lane = lane + k;

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        lane_nxt   = lane;
        last_k_nxt = last_k;
        base_nxt   = base;
        take_addr  = 1'b0;
        hreadyout  = 1'b1;
        hresp      = HRESP_OKAY;
        sram_cs    = 1'b0;
        sram_wen   = 1'b1;
        sram_addr  = '0;
        sram_data  = '0;

        case (state)
            ST_IDLE: take_addr = 1'b1;
            ST_WRITE: begin
                sram_cs   = 1'b1;
                sram_wen  = 1'b0;
                sram_addr = base + {{(ADDR_WIDTH-2){1'b0}}, k};
                sram_data = bus.hwdata[{byte_lane, 3'b000} +: 8];
                if (k == last_k) begin
                    take_addr = 1'b1;
                end else begin
                    hreadyout = 1'b0;
                    k_nxt     = k + 2'd1;
                end
            end
            ST_READ: begin
                sram_cs   = 1'b1;
                sram_addr = base + {{(ADDR_WIDTH-2){1'b0}}, k};
                hreadyout = 1'b0;
                if (k == last_k) begin
                    state_nxt = ST_RDLAST;
                end else begin
                    k_nxt = k + 2'd1;
                end
            end
            ST_RDLAST: take_addr = 1'b1;
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                hresp     = HRESP_ERROR;
                take_addr = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Any cycle with hreadyout=1 can take the next address phase, so strobes run without a bubble.
        if (take_addr) begin
            state_nxt = ST_IDLE;
            if (accept) begin
                base_nxt   = bus.haddr[ADDR_WIDTH-1:0];
                lane_nxt   = bus.haddr[1:0];
                last_k_nxt = size_last_k(bus.hsize);
                k_nxt      = 2'd0;
                if (illegal) begin
                    state_nxt = ST_ERR1;
                end else if (bus.hwrite) begin
                    state_nxt = ST_WRITE;
                end else begin
                    state_nxt = ST_READ;
                end
            end
        end
    end

    assign start_read  = take_addr & accept & ~illegal & ~bus.hwrite;
    assign rd_pend_nxt = (state == ST_READ);
    assign rd_lane_nxt = byte_lane;

    // sram_q lands one cycle after its strobe; merge it live so RDLAST presents the full word.
    always_comb begin
        rdata_merged = hrdata_q;
        if (rd_pend) begin
            rdata_merged[{rd_lane, 3'b000} +: 8] = bus.sram_q;
        end
    end

    assign hrdata_nxt = start_read ? 32'd0 : rdata_merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            k        <= 2'd0;
            lane     <= 2'd0;
            last_k   <= 2'd0;
            base     <= '0;
            rd_pend  <= 1'b0;
            rd_lane  <= 2'd0;
            hrdata_q <= 32'd0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            lane     <= lane_nxt;
            last_k   <= last_k_nxt;
            base     <= base_nxt;
            rd_pend  <= rd_pend_nxt;
            rd_lane  <= rd_lane_nxt;
            hrdata_q <= hrdata_nxt;
        end
    end

    assign bus.hreadyout = hreadyout;
    assign bus.hresp     = hresp;
    assign bus.hrdata    = rdata_merged;
    assign bus.sram_cs   = sram_cs;
    assign bus.sram_wen  = sram_wen;
    assign bus.sram_addr = sram_addr;
    assign bus.sram_data = sram_data;

endmodule

// File: tb/tb_ahb_lite_sp_sram_byte_ctrl.sv
// Directed bench: single-slave AHB bus, behavioural 2048x8 SRAM, strobe log.
module tb_ahb_lite_sp_sram_byte_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_lite_sp_sram_byte_ctrl_if #(.ADDR_WIDTH(11)) bus ();

    ahb_lite_sp_sram_byte_ctrl #(.ADDR_WIDTH(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [0:2047];
    logic [7:0] sram_q = 8'd0;

    assign bus.hready = bus.hreadyout;
    assign bus.sram_q = sram_q;

    always @(posedge clk) begin
        if (bus.sram_cs) begin
            if (!bus.sram_wen) mem[bus.sram_addr] <= bus.sram_data;
            sram_q <= mem[bus.sram_addr];
        end
    end

    logic [31:0] st_q [$];
    int          st_c [$];
    int          cyc_cnt = 0;

    always @(negedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (bus.sram_cs) begin
            st_q.push_back({7'b0, bus.sram_wen, 5'b0, bus.sram_addr, bus.sram_data});
            st_c.push_back(cyc_cnt);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_strobe(input string tag, input logic wen, input logic [10:0] addr,
                                 input logic [7:0] data, output int cyc);
        logic [31:0] got;
        cyc = -1;
        chk({tag, "_present"}, 32'(st_q.size() != 0), 32'd1);
        if (st_q.size() != 0) begin
            got = st_q.pop_front();
            cyc = st_c.pop_front();
            chk(tag, got, {7'b0, wen, 5'b0, addr, data});
        end
    endtask

    task automatic clear_log();
        st_q.delete();
        st_c.delete();
    endtask

    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata, output int waits, output logic [31:0] rdata,
                           output logic resp_first, output logic resp_last, output logic done);
        bus.hsel   = 1'b1;
        bus.htrans = 2'b10;
        bus.haddr  = addr;
        bus.hwrite = wr;
        bus.hsize  = size;
        @(posedge clk); #1;
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        bus.haddr  = 32'd0;
        bus.hwrite = 1'b0;
        bus.hsize  = 3'd0;
        bus.hwdata = wdata;
        waits = 0; done = 1'b0; rdata = 32'd0; resp_last = 1'b0;
        @(negedge clk);
        resp_first = bus.hresp;
        for (int i = 0; i < 16; i++) begin
            if (bus.hreadyout) begin
                done      = 1'b1;
                rdata     = bus.hrdata;
                resp_last = bus.hresp;
                break;
            end
            waits++;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    int          waits, c0, c1, cx;
    logic [31:0] rdata;
    logic        rf, rl, done;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = 32'd0; bus.hwrite = 1'b0;
        bus.hsize = 3'd0; bus.hwdata = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
        chk("rst_hresp",     32'(bus.hresp),     32'd0);
        chk("rst_hrdata",    bus.hrdata,         32'd0);
        chk("rst_cs_wen",    {30'd0, bus.sram_cs, bus.sram_wen}, 32'd1);
        chk("rst_addr_data", {13'd0, bus.sram_addr, bus.sram_data}, 32'd0);
        @(posedge clk); #1;

        // Word write
        clear_log();
        do_xfer(1'b1, 32'h0000_0010, 3'd2, 32'hA1B2_C3D4, waits, rdata, rf, rl, done);
        chk("ww_done", 32'(done), 32'd1);
        chk("ww_waits", 32'(waits), 32'd3);
        chk("ww_resp", 32'(rl), 32'd0);
        expect_strobe("ww_s0", 1'b0, 11'h010, 8'hD4, cx);
        expect_strobe("ww_s1", 1'b0, 11'h011, 8'hC3, cx);
        expect_strobe("ww_s2", 1'b0, 11'h012, 8'hB2, cx);
        expect_strobe("ww_s3", 1'b0, 11'h013, 8'hA1, cx);
        chk("ww_count", 32'(st_q.size()), 32'd0);

        // Word read
        clear_log();
        do_xfer(1'b0, 32'h0000_0010, 3'd2, 32'd0, waits, rdata, rf, rl, done);
        chk("wr_waits", 32'(waits), 32'd4);
        chk("wr_rdata", rdata, 32'hA1B2_C3D4);
        chk("wr_resp", 32'(rl), 32'd0);
        expect_strobe("wr_s0", 1'b1, 11'h010, 8'h00, cx);
        expect_strobe("wr_s3x", 1'b1, 11'h011, 8'h00, cx);
        expect_strobe("wr_s2", 1'b1, 11'h012, 8'h00, cx);
        expect_strobe("wr_s3", 1'b1, 11'h013, 8'h00, cx);

        // Byte read, top lane
        clear_log();
        do_xfer(1'b0, 32'h0000_0013, 3'd0, 32'd0, waits, rdata, rf, rl, done);
        chk("br_waits", 32'(waits), 32'd1);
        chk("br_rdata", rdata, 32'hA100_0000);
        expect_strobe("br_s0", 1'b1, 11'h013, 8'h00, cx);
        chk("br_count", 32'(st_q.size()), 32'd0);

        // Halfword read through an aliased address
        clear_log();
        do_xfer(1'b0, 32'h0000_0812, 3'd1, 32'd0, waits, rdata, rf, rl, done);
        chk("hr_waits", 32'(waits), 32'd2);
        chk("hr_rdata", rdata, 32'hA1B2_0000);
        expect_strobe("hr_s0", 1'b1, 11'h012, 8'h00, cx);
        expect_strobe("hr_s1", 1'b1, 11'h013, 8'h00, cx);

        // Misaligned halfword write and oversized read
        clear_log();
        do_xfer(1'b1, 32'h0000_0011, 3'd1, 32'hFFFF_FFFF, waits, rdata, rf, rl, done);
        chk("eh_waits", 32'(waits), 32'd1);
        chk("eh_resp", {30'd0, rf, rl}, 32'd3);
        do_xfer(1'b0, 32'h0000_0010, 3'd3, 32'd0, waits, rdata, rf, rl, done);
        chk("es_waits", 32'(waits), 32'd1);
        chk("es_resp", {30'd0, rf, rl}, 32'd3);
        chk("err_nostrobe", 32'(st_q.size()), 32'd0);

        // Back-to-back word write then word read at the top of memory
        clear_log();
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h0000_07FC;
        bus.hwrite = 1'b1; bus.hsize = 3'd2;
        @(posedge clk); #1;
        bus.hwdata = 32'h1122_3344;
        bus.hwrite = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.hreadyout) begin
                done = 1'b1;
                break;
            end
        end
        chk("b2b_wr_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        waits = 0; done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.hreadyout) begin
                done = 1'b1;
                break;
            end
            waits++;
        end
        chk("b2b_rd_waits", 32'(waits), 32'd4);
        chk("b2b_rd_rdata", bus.hrdata, 32'h1122_3344);
        @(posedge clk); #1;
        expect_strobe("b2b_w0", 1'b0, 11'h7FC, 8'h44, c0);
        expect_strobe("b2b_w1", 1'b0, 11'h7FD, 8'h33, cx);
        expect_strobe("b2b_w2", 1'b0, 11'h7FE, 8'h22, cx);
        expect_strobe("b2b_w3", 1'b0, 11'h7FF, 8'h11, cx);
        expect_strobe("b2b_r0", 1'b1, 11'h7FC, 8'h00, cx);
        expect_strobe("b2b_r1", 1'b1, 11'h7FD, 8'h00, cx);
        expect_strobe("b2b_r2", 1'b1, 11'h7FE, 8'h00, cx);
        expect_strobe("b2b_r3", 1'b1, 11'h7FF, 8'h00, c1);
        chk("b2b_span", 32'(c1 - c0), 32'd7);

        // IDLE, BUSY and unselected NONSEQ complete zero-wait and leave hrdata alone
        for (int p = 0; p < 3; p++) begin
            clear_log();
            bus.hsel   = (p != 2);
            bus.htrans = (p == 0) ? 2'b00 : (p == 1) ? 2'b01 : 2'b10;
            bus.haddr  = 32'h0000_0010;
            bus.hwrite = 1'b0;
            bus.hsize  = 3'd2;
            @(posedge clk); #1;
            bus.hsel = 1'b0; bus.htrans = 2'b00;
            @(negedge clk);
            chk($sformatf("idle%0d_ready", p), {30'd0, bus.hreadyout, bus.hresp}, 32'd2);
            chk($sformatf("idle%0d_hrdata", p), bus.hrdata, 32'h1122_3344);
            chk($sformatf("idle%0d_nostrobe", p), 32'(st_q.size()), 32'd0);
            @(posedge clk); #1;
        end

        // Reset during the second cycle of a word read
        clear_log();
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h0000_0010;
        bus.hwrite = 1'b0; bus.hsize = 3'd2;
        @(posedge clk); #1;
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_cs", 32'(bus.sram_cs), 32'd0);
        chk("mrst_ready", {30'd0, bus.hreadyout, bus.hresp}, 32'd2);
        chk("mrst_hrdata", bus.hrdata, 32'd0);
        @(negedge clk);
        chk("mrst_strobes", 32'(st_q.size()), 32'd2);
        @(posedge clk); #1;

        clear_log();
        do_xfer(1'b0, 32'h0000_07FC, 3'd2, 32'd0, waits, rdata, rf, rl, done);
        chk("pr_waits", 32'(waits), 32'd4);
        chk("pr_rdata", rdata, 32'h1122_3344);

        // Byte write into lane 1, then read it back
        clear_log();
        do_xfer(1'b1, 32'h0000_0005, 3'd0, 32'h0000_AB00, waits, rdata, rf, rl, done);
        chk("bw_waits", 32'(waits), 32'd0);
        expect_strobe("bw_s0", 1'b0, 11'h005, 8'hAB, cx);
        do_xfer(1'b0, 32'h0000_0005, 3'd0, 32'd0, waits, rdata, rf, rl, done);
        chk("bwr_rdata", rdata, 32'h0000_AB00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
